// File: rtl/data_memory_unit.sv
`timescale 1ns/1ps
// MEM-stage data memory: single-port byte-enabled stores, sign/zero-extended loads,
// alignment error responses with a saturating error count, and a priority debug read port.
module data_memory_unit #(
    parameter int NB_DATA_BUS = 32,
    parameter int N_WORDS     = 64,
    parameter int NB_ADDRESS  = $clog2(N_WORDS) + $clog2(NB_DATA_BUS / 8),
    parameter int NB_ERR_CNT  = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_we,
    input  logic [1:0]                 i_req_size,
    input  logic                       i_req_signed,
    input  logic [NB_ADDRESS-1:0]      i_req_addr,
    input  logic [NB_DATA_BUS-1:0]     i_req_wdata,
    output logic                       o_rsp_valid,
    output logic [NB_DATA_BUS-1:0]     o_rsp_data,
    output logic                       o_rsp_err,
    input  logic                       i_dbg_rd_en,
    input  logic [$clog2(N_WORDS)-1:0] i_dbg_addr,
    output logic                       o_dbg_valid,
    output logic [NB_DATA_BUS-1:0]     o_dbg_data,
    output logic [NB_ERR_CNT-1:0]      o_err_cnt
);

    localparam int NB_LANES = NB_DATA_BUS / 8;
    localparam int NB_LANE  = $clog2(NB_LANES);
    localparam int NB_WIDX  = $clog2(N_WORDS);

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_DWORD = 2'b10;
    localparam logic [1:0] SZ_WORD  = 2'b11;

    localparam logic [NB_ERR_CNT-1:0] ERR_MAX = {NB_ERR_CNT{1'b1}};

    function automatic logic [NB_LANES-1:0] size_lanes(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_BYTE:  m = 8'h01;
            SZ_HALF:  m = 8'h03;
            SZ_WORD:  m = 8'h0F;
            SZ_DWORD: m = 8'hFF;
            default:  m = 8'h00;
        endcase
        return m[NB_LANES-1:0];
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [NB_LANE-1:0] lane);
        logic ok;
        case (size)
            SZ_BYTE:  ok = 1'b1;
            SZ_HALF:  ok = (lane[0] == 1'b0);
            SZ_WORD:  ok = (lane[1:0] == 2'b00);
            SZ_DWORD: ok = (NB_DATA_BUS == 64) && (lane == {NB_LANE{1'b0}});
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Selected lanes are shifted to bit 0; bits above the access size are filled by the masked sign.
    function automatic logic [NB_DATA_BUS-1:0] extend_load(
        input logic [NB_DATA_BUS-1:0] word,
        input logic [NB_LANE-1:0]     lane,
        input logic [1:0]             size,
        input logic                   sgn
    );
        logic [NB_DATA_BUS-1:0] shifted;
        logic [NB_DATA_BUS-1:0] keep_m;
        logic                   msb;
        shifted = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: begin
                keep_m = NB_DATA_BUS'(8'hFF);
                msb    = shifted[7];
            end
            SZ_HALF: begin
                keep_m = NB_DATA_BUS'(16'hFFFF);
                msb    = shifted[15];
            end
            SZ_WORD: begin
                keep_m = NB_DATA_BUS'(32'hFFFF_FFFF);
                msb    = shifted[31];
            end
            default: begin
                keep_m = {NB_DATA_BUS{1'b1}};
                msb    = 1'b0;
            end
        endcase
        return (shifted & keep_m) | ((sgn & msb) ? ~keep_m : {NB_DATA_BUS{1'b0}});
    endfunction

    logic [NB_DATA_BUS-1:0] mem [N_WORDS];

    logic [NB_LANE-1:0]     lane_s;
    logic [NB_WIDX-1:0]     widx_s;
    logic                   accept_s;
    logic                   legal_s;
    logic                   wr_en_s;
    logic [NB_LANES-1:0]    be_s;
    logic [NB_DATA_BUS-1:0] wdata_s;

    logic                   rsp_valid_r;
    logic [NB_DATA_BUS-1:0] rsp_data_r;
    logic                   rsp_err_r;
    logic                   dbg_valid_r;
    logic [NB_DATA_BUS-1:0] dbg_data_r;
    logic [NB_ERR_CNT-1:0]  err_cnt_r;

    assign o_req_ready = ~i_dbg_rd_en;

    // Request decode: address split, acceptance, legality and byte-lane write controls.
    always_comb begin
        lane_s   = i_req_addr[NB_LANE-1:0];
        widx_s   = i_req_addr[NB_ADDRESS-1:NB_LANE];
        accept_s = i_req_valid & ~i_dbg_rd_en;
        legal_s  = is_aligned(i_req_size, lane_s);
        wr_en_s  = accept_s & legal_s & i_req_we & ~i_reset;
        be_s     = size_lanes(i_req_size) << lane_s;
        wdata_s  = i_req_wdata << {lane_s, 3'b000};
    end

    // Memory array write; contents are intentionally left unreset.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < NB_LANES; i++) begin
                if (be_s[i]) begin
                    mem[widx_s][i*8 +: 8] <= wdata_s[i*8 +: 8];
                end
            end
        end
    end

    // Response register: one pulse per accepted request, data only for legal loads.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {NB_DATA_BUS{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= ~legal_s;
            if (legal_s && !i_req_we) begin
                rsp_data_r <= extend_load(mem[widx_s], lane_s, i_req_size, i_req_signed);
            end else begin
                rsp_data_r <= {NB_DATA_BUS{1'b0}};
            end
        end else begin
            rsp_valid_r <= 1'b0;
        end
    end

    // Saturating count of error responses.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            err_cnt_r <= {NB_ERR_CNT{1'b0}};
        end else if (accept_s && !legal_s && (err_cnt_r != ERR_MAX)) begin
            err_cnt_r <= err_cnt_r + 1'b1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    // Debug read port: raw word one cycle after the request.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            dbg_valid_r <= 1'b0;
            dbg_data_r  <= {NB_DATA_BUS{1'b0}};
        end else begin
            dbg_valid_r <= i_dbg_rd_en;
            if (i_dbg_rd_en) begin
                dbg_data_r <= mem[i_dbg_addr];
            end else begin
                dbg_data_r <= dbg_data_r;
            end
        end
    end

    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_data  = rsp_data_r;
    assign o_rsp_err   = rsp_err_r;
    assign o_dbg_valid = dbg_valid_r;
    assign o_dbg_data  = dbg_data_r;
    assign o_err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_data_memory_unit.sv
`timescale 1ns/1ps
// Randomised bench for data_memory_unit: a 32-bit and a 64-bit instance checked against
// a byte-addressed little-endian reference memory.
module tb_data_memory_unit;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_D = 2'b10;
    localparam logic [1:0] SZ_W = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v32, we32, sg32, rdy32, rv32, re32, dv32, dbg32;
    logic [1:0]  sz32;
    logic [7:0]  a32;
    logic [31:0] wd32, rd32, dd32;
    logic [5:0]  da32;
    logic [7:0]  ec32;

    logic        v64, we64, sg64, rdy64, rv64, re64, dv64, dbg64;
    logic [1:0]  sz64;
    logic [8:0]  a64;
    logic [63:0] wd64, rd64, dd64;
    logic [5:0]  da64;
    logic [7:0]  ec64;

    data_memory_unit #(.NB_DATA_BUS(32), .N_WORDS(64), .NB_ERR_CNT(8)) dut32 (
        .i_clk(clk), .i_reset(rst), .i_req_valid(v32), .o_req_ready(rdy32),
        .i_req_we(we32), .i_req_size(sz32), .i_req_signed(sg32), .i_req_addr(a32),
        .i_req_wdata(wd32), .o_rsp_valid(rv32), .o_rsp_data(rd32), .o_rsp_err(re32),
        .i_dbg_rd_en(dbg32), .i_dbg_addr(da32), .o_dbg_valid(dv32), .o_dbg_data(dd32),
        .o_err_cnt(ec32)
    );

    data_memory_unit #(.NB_DATA_BUS(64), .N_WORDS(64), .NB_ERR_CNT(8)) dut64 (
        .i_clk(clk), .i_reset(rst), .i_req_valid(v64), .o_req_ready(rdy64),
        .i_req_we(we64), .i_req_size(sz64), .i_req_signed(sg64), .i_req_addr(a64),
        .i_req_wdata(wd64), .o_rsp_valid(rv64), .o_rsp_data(rd64), .o_rsp_err(re64),
        .i_dbg_rd_en(dbg64), .i_dbg_addr(da64), .o_dbg_valid(dv64), .o_dbg_data(dd64),
        .o_err_cnt(ec64)
    );

    int errors = 0;
    int checks = 0;
    bit [7:0] mdl [2][512];
    int ecnt [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 1;
            SZ_H:    return 2;
            SZ_W:    return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] mdl_word(input int inst, input int idx);
        int nb = (inst == 0) ? 4 : 8;
        logic [63:0] v = 64'd0;
        for (int k = 0; k < nb; k++) v |= 64'(mdl[inst][idx*nb + k]) << (8*k);
        return v;
    endfunction

    function automatic logic [63:0] mdl_load(input int inst, input int addr, input int nb, input bit sgn);
        int w = (inst == 0) ? 32 : 64;
        logic [63:0] v = 64'd0;
        for (int k = 0; k < nb; k++) v |= 64'(mdl[inst][addr + k]) << (8*k);
        if (sgn && (nb*8 < w) && v[nb*8-1]) v |= ~((64'd1 << (nb*8)) - 64'd1);
        if (w == 32) v &= 64'hFFFF_FFFF;
        return v;
    endfunction

    // One clock of stimulus on one instance (the other is held idle), then checks of everything it affects.
    task automatic op(input int inst, input bit valid, input bit we, input logic [1:0] sz, input bit sgn,
                      input int addr, input logic [63:0] wd, input bit dbg, input int daddr);
        int w = (inst == 0) ? 32 : 64;
        int nb = nbytes(sz);
        bit acc = valid && !dbg;
        bit legal = (nb <= w/8) && (addr % nb == 0);
        logic [63:0] exp_data = 64'd0;
        logic [63:0] exp_dbg;
        logic [63:0] g_rdy, g_rv, g_rd, g_re, g_dv, g_dd, g_ec;
        if (inst == 0) begin
            v32 = valid; we32 = we; sz32 = sz; sg32 = sgn; a32 = 8'(addr); wd32 = wd[31:0];
            dbg32 = dbg; da32 = 6'(daddr); v64 = 1'b0; dbg64 = 1'b0;
        end else begin
            v64 = valid; we64 = we; sz64 = sz; sg64 = sgn; a64 = 9'(addr); wd64 = wd;
            dbg64 = dbg; da64 = 6'(daddr); v32 = 1'b0; dbg32 = 1'b0;
        end
        exp_dbg = mdl_word(inst, daddr);
        if (acc && legal && !we) exp_data = mdl_load(inst, addr, nb, sgn);
        if (acc && legal && we) for (int k = 0; k < nb; k++) mdl[inst][addr + k] = wd[8*k +: 8];
        if (acc && !legal && ecnt[inst] < 255) ecnt[inst]++;
        #1;
        g_rdy = (inst == 0) ? 64'(rdy32) : 64'(rdy64);
        check($sformatf("req_ready%0d", w), g_rdy, 64'(!dbg));
        @(posedge clk);
        #1;
        g_rv = (inst == 0) ? 64'(rv32) : 64'(rv64);
        g_rd = (inst == 0) ? 64'(rd32) : rd64;
        g_re = (inst == 0) ? 64'(re32) : 64'(re64);
        g_dv = (inst == 0) ? 64'(dv32) : 64'(dv64);
        g_dd = (inst == 0) ? 64'(dd32) : dd64;
        g_ec = (inst == 0) ? 64'(ec32) : 64'(ec64);
        check($sformatf("rsp_valid%0d a=%0h", w, addr), g_rv, 64'(acc));
        if (acc) begin
            check($sformatf("rsp_data%0d a=%0h sz=%0d s=%0d we=%0d", w, addr, sz, sgn, we), g_rd, exp_data);
            check($sformatf("rsp_err%0d a=%0h sz=%0d", w, addr, sz), g_re, 64'(!legal));
        end
        check($sformatf("err_cnt%0d", w), g_ec, 64'(ecnt[inst]));
        check($sformatf("dbg_valid%0d", w), g_dv, 64'(dbg));
        if (dbg) check($sformatf("dbg_data%0d i=%0d", w, daddr), g_dd, exp_dbg);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rsp_valid32"}, 64'(rv32), 64'd0);
        check({tag, "_rsp_data32"}, 64'(rd32), 64'd0);
        check({tag, "_rsp_err32"}, 64'(re32), 64'd0);
        check({tag, "_dbg_valid32"}, 64'(dv32), 64'd0);
        check({tag, "_dbg_data32"}, 64'(dd32), 64'd0);
        check({tag, "_err_cnt32"}, 64'(ec32), 64'd0);
        check({tag, "_rsp_valid64"}, 64'(rv64), 64'd0);
        check({tag, "_rsp_data64"}, rd64, 64'd0);
        check({tag, "_err_cnt64"}, 64'(ec64), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        v32 = 1'b0; we32 = 1'b0; sz32 = SZ_B; sg32 = 1'b0; a32 = 8'd0; wd32 = 32'd0; dbg32 = 1'b0; da32 = 6'd0;
        v64 = 1'b0; we64 = 1'b0; sz64 = SZ_B; sg64 = 1'b0; a64 = 9'd0; wd64 = 64'd0; dbg64 = 1'b0; da64 = 6'd0;
        ecnt[0] = 0;
        ecnt[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 64; i++) begin
            op(0, 1'b1, 1'b1, SZ_W, 1'b0, i*4, {$urandom, $urandom}, 1'b0, 0);
            op(1, 1'b1, 1'b1, SZ_D, 1'b0, i*8, {$urandom, $urandom}, 1'b0, 0);
        end

        op(0, 1'b1, 1'b1, SZ_W, 1'b0, 'h08, 64'hDEADBEEF, 1'b0, 0);
        op(0, 1'b1, 1'b0, SZ_W, 1'b0, 'h08, 64'd0, 1'b0, 0);
        check("lit_word32", 64'(rd32), 64'hDEADBEEF);
        op(0, 1'b1, 1'b1, SZ_W, 1'b0, 'h08, 64'h11223344, 1'b0, 0);
        op(0, 1'b1, 1'b1, SZ_B, 1'b0, 'h0B, 64'h80, 1'b0, 0);
        op(0, 1'b1, 1'b0, SZ_B, 1'b1, 'h0B, 64'd0, 1'b0, 0);
        check("lit_byte_s", 64'(rd32), 64'hFFFFFF80);
        op(0, 1'b1, 1'b0, SZ_B, 1'b0, 'h0B, 64'd0, 1'b0, 0);
        op(0, 1'b1, 1'b0, SZ_W, 1'b0, 'h08, 64'd0, 1'b0, 0);
        check("lit_word_merge", 64'(rd32), 64'h80223344);
        op(0, 1'b1, 1'b0, SZ_H, 1'b1, 'h0A, 64'd0, 1'b0, 0);
        check("lit_half_s", 64'(rd32), 64'hFFFF8022);
        op(0, 1'b1, 1'b0, SZ_H, 1'b1, 'h09, 64'd0, 1'b0, 0);
        op(0, 1'b1, 1'b1, SZ_H, 1'b0, 'h09, 64'hFFFF, 1'b0, 0);
        op(0, 1'b1, 1'b0, SZ_W, 1'b0, 'h08, 64'd0, 1'b0, 0);
        op(0, 1'b1, 1'b0, SZ_D, 1'b0, 'h00, 64'd0, 1'b0, 0);

        op(0, 1'b1, 1'b0, SZ_W, 1'b0, 'h08, 64'd0, 1'b1, 2);
        op(0, 1'b1, 1'b0, SZ_W, 1'b0, 'h08, 64'd0, 1'b0, 0);

        op(1, 1'b1, 1'b1, SZ_D, 1'b0, 'h10, 64'h0123456789ABCDEF, 1'b0, 0);
        op(1, 1'b1, 1'b0, SZ_D, 1'b0, 'h10, 64'd0, 1'b0, 0);
        check("lit_dword64", rd64, 64'h0123456789ABCDEF);
        op(1, 1'b1, 1'b0, SZ_W, 1'b0, 'h14, 64'd0, 1'b0, 0);
        check("lit_word64_u", rd64, 64'h0000000001234567);
        op(1, 1'b1, 1'b0, SZ_W, 1'b1, 'h10, 64'd0, 1'b0, 0);
        op(1, 1'b1, 1'b0, SZ_D, 1'b0, 'h14, 64'd0, 1'b0, 0);
        op(1, 1'b1, 1'b0, SZ_B, 1'b1, 'h17, 64'd0, 1'b1, 2);

        for (int i = 0; i < 260; i++)
            op(0, 1'b1, 1'($urandom), SZ_H, 1'($urandom), 2*$urandom_range(127, 0) + 1,
               {$urandom, $urandom}, 1'b0, 0);
        check("err_cnt_sat", 64'(ec32), 64'd255);

        op(0, 1'b1, 1'b0, SZ_W, 1'b0, 'h08, 64'd0, 1'b0, 0);
        v32 = 1'b1; we32 = 1'b0; sz32 = SZ_W; a32 = 8'h0C;
        #2;
        rst = 1'b1;
        #1;
        check_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        v32 = 1'b0;
        rst = 1'b0;
        ecnt[0] = 0;
        ecnt[1] = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_rsp_valid", 64'(rv32), 64'd0);
        end

        for (int i = 0; i < 600; i++) begin
            int inst = i % 2;
            int w = (inst == 0) ? 32 : 64;
            logic [1:0] sz = 2'($urandom);
            int nb = nbytes(sz);
            int addr = $urandom_range((w == 32) ? 255 : 511, 0);
            if (($urandom % 4 != 0) && (nb <= w/8)) addr = addr - (addr % nb);
            op(inst, ($urandom % 8) != 0, 1'($urandom), sz, 1'($urandom), addr,
               {$urandom, $urandom}, ($urandom % 8) == 0, $urandom_range(63, 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Parametrised successor to the 32-bit data memory front-end: a single-port, synchronous-read data memory with byte/half/word/doubleword access, sign/zero extension, alignment checking with an error response, a valid/ready request handshake, and a debug read port for the debug unit. It sits in the MEM stage of the pipeline between the ALU result/store-data registers and the MEM/WB register, and is also read by the debug unit while the pipeline is halted.

## Interface
- NB_DATA_BUS, 32, memory word width in bits; legal values 32 or 64.
- N_WORDS, 64, memory depth in words.
- NB_ADDRESS, $clog2(N_WORDS)+$clog2(NB_DATA_BUS/8), byte-address width.
- NB_ERR_CNT, 8, width of the saturating misalignment counter.

- i_clk  in  1  clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted when valid & ready at a rising edge.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_size  in  2  00 byte, 01 half, 11 word, 10 doubleword (legal only if NB_DATA_BUS=64).
- i_req_signed  in  1  load: 1 = sign-extend, 0 = zero-extend; ignored for stores.
- i_req_addr  in  NB_ADDRESS  byte address.
- i_req_wdata  in  NB_DATA_BUS  store data, right-aligned (byte in [7:0], half in [15:0], ...).
- o_rsp_valid  out  1  one-cycle pulse per accepted request.
- o_rsp_data  out  NB_DATA_BUS  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  qualifies o_rsp_valid: misaligned/illegal request.
- i_dbg_rd_en  in  1  debug read request.
- i_dbg_addr  in  $clog2(N_WORDS)  debug word index.
- o_dbg_valid  out  1  debug data valid pulse.
- o_dbg_data  out  NB_DATA_BUS  raw memory word.
- o_err_cnt  out  NB_ERR_CNT  saturating count of error responses.

## Operation
- Lane select: lane = i_req_addr[$clog2(NB_DATA_BUS/8)-1:0]; word index = remaining upper bits.
- Alignment: byte always legal; half needs addr[0]=0; word needs addr[1:0]=0; doubleword needs addr[2:0]=0 and NB_DATA_BUS=64, otherwise illegal.
- Illegal request: accepted normally, no memory read or write, response has err=1, data=0, o_err_cnt += 1 saturating at all-ones.
- Store: byte-enable write (no read-modify-write); only lanes covered by size are written, taken from low bits of i_req_wdata; other bytes unchanged.
- Load: whole word read, selected lanes shifted to bit 0, extended to NB_DATA_BUS per i_req_signed; word on 64-bit bus extends from bit 31; doubleword/native-width load returns raw word.
- Debug port has priority: o_req_ready = ~i_dbg_rd_en; a debug read and a request are never serviced in the same cycle.
- Response has no backpressure; consumer must accept every o_rsp_valid.
- Memory contents are not reset and power up undefined.

## Timing
- Reset (asynchronous assert, synchronous release): o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_dbg_valid=0, o_dbg_data=0, o_err_cnt=0. o_req_ready is combinational (~i_dbg_rd_en), valid in reset.
- Request accepted at edge N -> o_rsp_valid/data/err valid during cycle N+1, deasserted at N+2 unless another request was accepted at N+1. Throughput one request per cycle.
- Store accepted at edge N writes memory at edge N; load accepted at edge N+1 to the same address returns the new data (no hazard window).
- Debug read sampled at edge N -> o_dbg_valid/o_dbg_data during cycle N+1.
- Reset asserted while a response is pending: response discarded, never emitted after release; a store accepted at the same edge reset asserts is not guaranteed to be written.
- o_rsp_data/o_dbg_data hold last value when valid low; only valid-qualified values are meaningful.

## Test plan
- Word store 0xDEADBEEF to addr 0x08, load word addr 0x08 next cycle -> rsp at N+1, data 0xDEADBEEF, err=0.
- Byte store 0x80 to addr 0x0B over 0x11223344, load byte signed addr 0x0B -> 0xFFFFFF80; unsigned -> 0x00000080; word load -> 0x80223344.
- Half load signed at addr 0x0A of 0x80223344 -> 0xFFFF8022; half load at addr 0x09 -> err=1, data 0, o_err_cnt 1, memory unchanged.
- NB_DATA_BUS=32: doubleword request at addr 0x00 -> err=1; NB_DATA_BUS=64: dword store/load at 0x10 round-trips 0x0123456789ABCDEF, word load at 0x14 unsigned -> 0x0000000001234567.
- i_dbg_rd_en high with i_req_valid high -> o_req_ready=0, request not accepted, o_dbg_data = stored word at N+1; request accepted the cycle after debug drops.
- 260 misaligned requests with NB_ERR_CNT=8 -> o_err_cnt saturates at 255; reset mid-stream -> all outputs 0, no stray o_rsp_valid after release.
